// File: rtl/cdc_toggle_arbiter.sv
// cdc_toggle_arbiter: round-robin arbiter for toggle-handshake requests from synchronized source domains
module cdc_toggle_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic               clk_sync,
    input  logic               arst_n,
    input  logic [NUM_REQ-1:0] req_tgl_i,
    input  logic               done_i,
    output logic               gnt_valid_o,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [NUM_REQ-1:0] ack_tgl_o,
    output logic               timeout_o,
    output logic [NUM_REQ-1:0] overrun_o
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [PW-1:0] PTR_LAST = PW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t             state, state_nx;
    logic [NUM_REQ-1:0] req_prev, pending, evt, rel_mask;
    logic [PW-1:0]      rr_ptr, sel, pick;
    logic [CW-1:0]      cnt;
    logic               do_grant, do_release, expire;

    assign evt      = req_tgl_i ^ req_prev;
    assign rel_mask = do_release ? gnt_o : '0;

    // Pick the first pending requester at or above rr_ptr, wrapping; scanning downward lets the nearest win.
    always_comb begin
        pick = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (pending[(int'(rr_ptr) + i) % NUM_REQ]) pick = PW'((int'(rr_ptr) + i) % NUM_REQ);
    end

    // Next-state logic and the grant/release strobes; a coincident done_i wins over the timeout.
    always_comb begin
        state_nx   = state;
        do_grant   = 1'b0;
        do_release = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                do_grant = |pending;
                state_nx = do_grant ? GRANT : IDLE;
            end
            GRANT: begin
                expire     = (TIMEOUT_CYCLES > 0) && !done_i && (cnt == CNT_LAST);
                do_release = done_i || expire;
                state_nx   = do_release ? RELEASE : GRANT;
            end
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_sync or negedge arst_n) begin
        if (!arst_n) state <= IDLE;
        else         state <= state_nx;
    end

    // Event capture, grant/ack bookkeeping and the GRANT cycle counter.
    always_ff @(posedge clk_sync or negedge arst_n) begin
        if (!arst_n) begin
            req_prev    <= '0;
            pending     <= '0;
            overrun_o   <= '0;
            timeout_o   <= 1'b0;
            gnt_valid_o <= 1'b0;
            gnt_o       <= '0;
            ack_tgl_o   <= '0;
            rr_ptr      <= '0;
            sel         <= '0;
            cnt         <= '0;
        end else begin
            req_prev  <= req_tgl_i;
            pending   <= (pending & ~rel_mask) | evt;
            overrun_o <= overrun_o | (evt & pending);
            timeout_o <= expire;
            if (do_grant) begin
                sel         <= pick;
                gnt_o       <= NUM_REQ'(1) << pick;
                gnt_valid_o <= 1'b1;
                cnt         <= '0;
            end else if (do_release) begin
                gnt_o       <= '0;
                gnt_valid_o <= 1'b0;
                ack_tgl_o   <= ack_tgl_o ^ gnt_o;
                rr_ptr      <= (sel == PTR_LAST) ? '0 : sel + 1'b1;
            end else if (state == GRANT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/cdc_toggle_arbiter.md
CDC_TOGGLE_ARBITER -- requirements
Module: cdc_toggle_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning the maximum number of GRANT cycles before a forced release; 0 disables the timeout.
REQ-003 SHALL have port clk_sync, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port arst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_tgl_i, input, NUM_REQ bits: per-requester request toggles, already synchronized by 3-FF synchronizers outside this block.
REQ-006 SHALL have port done_i, input, 1 bit: the shared resource reports completion of the granted transaction.
REQ-007 SHALL have port gnt_valid_o, output, 1 bit: a grant is active.
REQ-008 SHALL have port gnt_o, output, NUM_REQ bits: one-hot grant; all zero when gnt_valid_o=0.
REQ-009 SHALL have port ack_tgl_o, output, NUM_REQ bits: per-requester acknowledge toggles, returned to the source domains through synchronizers.
REQ-010 SHALL have port timeout_o, output, 1 bit: one-cycle pulse on a forced release.
REQ-011 SHALL have port overrun_o, output, NUM_REQ bits: sticky flag, set when a new toggle arrives while that requester is still pending.

Function
REQ-012 SHALL register req_tgl_i into req_prev every cycle; bit i SHALL detect an event when req_tgl_i[i] != req_prev[i].
REQ-013 SHALL set pending[i] on the edge where the event is sampled; pending[i] SHALL clear only on release of requester i.
REQ-014 SHALL set overrun_o[i] on an event while pending[i]=1; the event SHALL NOT be queued twice; overrun_o[i] clears only on reset.
REQ-015 SHALL implement the FSM states IDLE, GRANT and RELEASE; the reset state SHALL be IDLE.
REQ-016 IDLE: if any pending bit is set, SHALL select the first pending index searching upward from rr_ptr with wrap; SHALL register gnt_o and gnt_valid_o=1; SHALL go to GRANT. Otherwise it SHALL stay in IDLE.
REQ-017 Latency: a toggle on req_tgl_i in cycle k, with the FSM in IDLE, SHALL give gnt_valid_o=1 after edge k+2.
REQ-018 GRANT: done_i=1 SHALL cause the following on the same edge:
- toggle ack_tgl_o[sel];
- clear pending[sel];
- set rr_ptr = (sel+1) mod NUM_REQ;
- clear gnt_valid_o and gnt_o;
- go to RELEASE.
REQ-019 GRANT timeout: with TIMEOUT_CYCLES>0, a cycle counter SHALL clear on entry to GRANT and increment each GRANT cycle with done_i=0. When count == TIMEOUT_CYCLES-1 and done_i=0, the block SHALL perform the REQ-018 release and pulse timeout_o for one cycle.
REQ-020 If done_i and the timeout condition coincide, the release SHALL be a normal completion with no timeout_o pulse.
REQ-021 RELEASE SHALL last exactly one cycle and then go to IDLE; gnt_valid_o SHALL be low for at least 2 cycles between consecutive grants.
REQ-022 done_i SHALL be ignored in IDLE and RELEASE.
REQ-023 Events on any requester, including the granted one, SHALL be captured in every state without loss.
REQ-024 gnt_o SHALL remain stable for the whole of GRANT.

Reset
REQ-025 On arst_n=0 the following SHALL reset asynchronously:
- state=IDLE; rr_ptr=0; counter=0;
- req_prev=0; pending=0;
- gnt_valid_o=0; gnt_o=0; ack_tgl_o=0; timeout_o=0; overrun_o=0.
REQ-026 Reset mid-GRANT SHALL drop the grant immediately, with no ack toggle; release of reset SHALL be synchronous to clk_sync.
REQ-027 If req_tgl_i[i]=1 on the first cycle after reset, it SHALL be treated as an event.

Verification
REQ-028 Single request: NUM_REQ=4; req_tgl_i[2] goes 0->1 at cycle 10 -> gnt_o=4'b0100 and gnt_valid_o=1 from cycle 12; done_i at cycle 15 -> ack_tgl_o[2]=1 from cycle 16, grant low, rr_ptr=3.
REQ-029 Round-robin: all 4 requests toggle in the same cycle with rr_ptr=0 -> grant order 0,1,2,3; each grant separated by 2 idle cycles; each ack toggles once.
REQ-030 Timeout: TIMEOUT_CYCLES=8; request 1 granted, done_i held 0 -> release after 8 GRANT cycles; timeout_o high 1 cycle; ack_tgl_o[1] toggles.
REQ-031 Coincidence: done_i asserted in GRANT cycle 7 with TIMEOUT_CYCLES=8 -> normal release; timeout_o stays 0.
REQ-032 Overrun: req_tgl_i[0] toggles twice before its grant -> overrun_o[0]=1; exactly one grant and one ack for requester 0.
REQ-033 Reset mid-grant: arst_n low during GRANT for requester 3 -> gnt_valid_o=0 immediately; after reset, all outputs are zero and no ack toggle has occurred.
